// File: rtl/cam_frame_writer.sv
// Camera-to-frame-RAM writer: packs RGB444 byte pairs into 12-bit pixels and writes them linearly.
// Latency: one clk from the second byte of a pixel to its WriteEn strobe; SyncVsync on the frame-start cycle.
// Backpressure: none; the RAM port must accept every WriteEn, and bytes outside the frame window are dropped.
module cam_frame_writer #(
  parameter int H_PIXELS  = 320,
  parameter int V_LINES   = 480,
  parameter int SYNC_ONCE = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        enable,
  input  logic        cam_pclk_en,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  output logic [18:0] WriteAdd,
  output logic [11:0] WriteData,
  output logic        WriteEn,
  output logic        SyncVsync,
  output logic        frame_done,
  output logic        busy
);

  typedef enum logic {WAIT_VS = 1'b0, CAPTURE = 1'b1} state_t;

  localparam logic [9:0]  H_W       = 10'(H_PIXELS);
  localparam logic [9:0]  V_W       = 10'(V_LINES);
  localparam logic [18:0] LAST_ADDR = 19'(H_PIXELS * V_LINES - 1);

  state_t      state_q;
  logic        vs_q, hr_q;
  logic        phase_q, phase_d;
  logic [3:0]  r_q, r_d;
  logic [9:0]  pix_q, pix_d, pix_inc;
  logic [9:0]  line_q, line_d;
  logic [18:0] naddr_q, naddr_d;   // address the next stored pixel will use
  logic        sync_sent_q;
  logic        done_q;             // frame_done already issued for this frame
  logic [18:0] wadd_q;
  logic [11:0] wdat_q;
  logic        wen_q, sync_q, fdone_q, busy_q;

  logic        vs_fall, vs_rise, line_end;
  logic        accept, pix_formed, store, last_wr;
  logic [11:0] pixel;

  assign vs_fall    = vs_q & ~cam_vsync;
  assign vs_rise    = ~vs_q & cam_vsync;
  assign line_end   = (state_q == CAPTURE) & hr_q & ~cam_href & ~vs_rise;
  assign accept     = (state_q == CAPTURE) & cam_pclk_en & cam_href & ~vs_rise;
  assign pix_formed = accept & phase_q;
  assign store      = pix_formed & (pix_q < H_W) & (line_q < V_W);
  assign pixel      = {cam_data[3:0], cam_data[7:4], r_q};
  assign last_wr    = wen_q & (wadd_q == LAST_ADDR);

  // Byte packing and position counters: byte effects first, then any line end on top.
  always_comb begin
    phase_d = phase_q;
    r_d     = r_q;
    pix_inc = pix_q;
    line_d  = line_q;
    naddr_d = naddr_q;
    if (accept) begin
      phase_d = ~phase_q;
      if (!phase_q) r_d = cam_data[3:0];
    end
    if (pix_formed && (pix_q < H_W)) pix_inc = pix_q + 10'd1;
    if (store) naddr_d = naddr_q + 19'd1;
    pix_d = pix_inc;
    if (line_end) begin
      phase_d = 1'b0;
      pix_d   = 10'd0;
      if (line_q < V_W) begin
        line_d  = line_q + 10'd1;
        // Short lines leave a gap in RAM so the next line starts on its row boundary.
        naddr_d = naddr_d + 19'(H_W - pix_inc);
      end
    end
  end

  // Capture FSM with registered outputs and the RAM write port.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= WAIT_VS;
      vs_q        <= 1'b0;
      hr_q        <= 1'b0;
      phase_q     <= 1'b0;
      r_q         <= 4'd0;
      pix_q       <= 10'd0;
      line_q      <= 10'd0;
      naddr_q     <= 19'd0;
      sync_sent_q <= 1'b0;
      done_q      <= 1'b0;
      wadd_q      <= 19'd0;
      wdat_q      <= 12'd0;
      wen_q       <= 1'b0;
      sync_q      <= 1'b0;
      fdone_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      vs_q    <= cam_vsync;
      hr_q    <= cam_href;
      wen_q   <= store;
      sync_q  <= 1'b0;
      fdone_q <= 1'b0;
      if (store) begin
        wdat_q <= pixel;
        wadd_q <= naddr_q;
      end
      if (!enable) sync_sent_q <= 1'b0;
      // The final write of a full frame may still land after the state has returned to WAIT_VS.
      if (last_wr) begin
        fdone_q <= 1'b1;
        done_q  <= 1'b1;
      end
      case (state_q)
        WAIT_VS: begin
          if (vs_fall && enable) begin
            state_q <= CAPTURE;
            busy_q  <= 1'b1;
            naddr_q <= 19'd0;
            wadd_q  <= 19'd0;
            line_q  <= 10'd0;
            pix_q   <= 10'd0;
            phase_q <= 1'b0;
            done_q  <= 1'b0;
            if ((SYNC_ONCE == 0) || !sync_sent_q) begin
              sync_q      <= 1'b1;
              sync_sent_q <= 1'b1;
            end
          end
        end
        default: begin
          phase_q <= phase_d;
          r_q     <= r_d;
          pix_q   <= pix_d;
          line_q  <= line_d;
          naddr_q <= naddr_d;
          if (vs_rise) begin
            state_q <= WAIT_VS;
            busy_q  <= 1'b0;
            phase_q <= 1'b0;
            done_q  <= 1'b1;
            if (!done_q && !last_wr) fdone_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign WriteAdd   = wadd_q;
  assign WriteData  = wdat_q;
  assign WriteEn    = wen_q;
  assign SyncVsync  = sync_q;
  assign frame_done = fdone_q;
  assign busy       = busy_q;

endmodule
